// File: rtl/hazard_tnew_tracker_if.sv
// D-stage hazard query bus between the decoder (master) and the Tnew tracker (slave).
interface hazard_tnew_tracker_if #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned TW    = 2,
  parameter int unsigned SELW  = 2
);
  logic                d_valid;
  logic                d_rs_use;
  logic [4:0]          d_rs_addr;
  logic [TW-1:0]       d_rs_tuse;
  logic                d_rt_use;
  logic [4:0]          d_rt_addr;
  logic [TW-1:0]       d_rt_tuse;
  logic                d_wr_en;
  logic [4:0]          d_wr_addr;
  logic [TW-1:0]       d_tnew;
  logic                d_md_op;
  logic                d_md_start;
  logic                flush_e;
  logic                stall;
  logic [SELW-1:0]     fwd_rs_sel;
  logic [SELW-1:0]     fwd_rt_sel;
  logic [DEPTH*TW-1:0] tnew_vec;
  logic                md_busy;

  modport master (
    output d_valid, d_rs_use, d_rs_addr, d_rs_tuse, d_rt_use, d_rt_addr, d_rt_tuse,
           d_wr_en, d_wr_addr, d_tnew, d_md_op, d_md_start, flush_e,
    input  stall, fwd_rs_sel, fwd_rt_sel, tnew_vec, md_busy
  );

  modport slave (
    input  d_valid, d_rs_use, d_rs_addr, d_rs_tuse, d_rt_use, d_rt_addr, d_rt_tuse,
           d_wr_en, d_wr_addr, d_tnew, d_md_op, d_md_start, flush_e,
    output stall, fwd_rs_sel, fwd_rt_sel, tnew_vec, md_busy
  );
endinterface

// File: rtl/hazard_tnew_tracker.sv
// Tuse/Tnew hazard unit: tracks DEPTH post-D stages, drives stall and forward select,
// and interlocks the multicycle mult/div unit with a busy counter.
module hazard_tnew_tracker #(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned TW     = 2,
  parameter int unsigned MD_LAT = 5,
  parameter int unsigned SELW   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  hazard_tnew_tracker_if.slave  hz
);
  localparam int unsigned AW  = 5;
  localparam int unsigned MDW = $clog2(MD_LAT + 1);

  logic          st_valid [1:DEPTH];
  logic [AW-1:0] st_addr  [1:DEPTH];
  logic [TW-1:0] st_tnew  [1:DEPTH];
  logic [MDW-1:0] md_cnt;

  logic            md_busy_c;
  logic            accept_c;
  logic            stall_c;
  logic            rs_hit_c, rt_hit_c;
  logic [SELW-1:0] rs_sel_c, rt_sel_c;
  logic [TW-1:0]   rs_tnew_c, rt_tnew_c;

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
    return (t == '0) ? t : t - TW'(1);
  endfunction

  assign md_busy_c = (md_cnt != '0);
  assign accept_c  = hz.d_valid && !stall_c && !hz.flush_e;

  // Youngest match wins: scan oldest to youngest so the lowest k overwrites.
  always_comb begin
    rs_hit_c  = 1'b0;
    rs_sel_c  = '0;
    rs_tnew_c = '0;
    rt_hit_c  = 1'b0;
    rt_sel_c  = '0;
    rt_tnew_c = '0;
    for (int k = int'(DEPTH); k >= 1; k--) begin
      if (hz.d_rs_use && st_valid[k] && (st_addr[k] == hz.d_rs_addr) && (hz.d_rs_addr != '0)) begin
        rs_hit_c  = 1'b1;
        rs_sel_c  = SELW'(k);
        rs_tnew_c = st_tnew[k];
      end
      if (hz.d_rt_use && st_valid[k] && (st_addr[k] == hz.d_rt_addr) && (hz.d_rt_addr != '0)) begin
        rt_hit_c  = 1'b1;
        rt_sel_c  = SELW'(k);
        rt_tnew_c = st_tnew[k];
      end
    end
  end

  always_comb begin
    stall_c = hz.d_valid && ((rs_hit_c && (rs_tnew_c > hz.d_rs_tuse)) ||
                             (rt_hit_c && (rt_tnew_c > hz.d_rt_tuse)) ||
                             (hz.d_md_op && md_busy_c));
  end

  // Stage pipeline: stage 1 takes the accepted D instruction or a bubble, older stages age.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= int'(DEPTH); k++) begin
        st_valid[k] <= 1'b0;
        st_addr[k]  <= '0;
        st_tnew[k]  <= '0;
      end
    end else begin
      st_valid[1] <= accept_c && hz.d_wr_en;
      st_addr[1]  <= accept_c ? hz.d_wr_addr : '0;
      st_tnew[1]  <= accept_c ? hz.d_tnew : '0;
      for (int k = 1; k < int'(DEPTH); k++) begin
        st_valid[k+1] <= st_valid[k];
        st_addr[k+1]  <= st_addr[k];
        st_tnew[k+1]  <= dec_sat(st_tnew[k]);
      end
    end
  end

  // Mult/div busy counter; a start while busy is blocked by the md_op stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (accept_c && hz.d_md_start) begin
      md_cnt <= MDW'(MD_LAT);
    end else if (md_busy_c) begin
      md_cnt <= md_cnt - MDW'(1);
    end
  end

  assign hz.stall      = stall_c;
  assign hz.fwd_rs_sel = rs_sel_c;
  assign hz.fwd_rt_sel = rt_sel_c;
  assign hz.md_busy    = md_busy_c;

  for (genvar g = 1; g <= int'(DEPTH); g++) begin : g_tvec
    assign hz.tnew_vec[(g-1)*TW +: TW] = st_tnew[g];
  end
endmodule

// File: tb/tb_hazard_tnew_tracker.sv
// Scoreboard bench for hazard_tnew_tracker: directed MIPS-style sequences with hand-computed outputs.
module tb_hazard_tnew_tracker;
  logic clk;
  logic reset;

  hazard_tnew_tracker_if #(.DEPTH(3), .TW(2), .SELW(2)) hz();

  hazard_tnew_tracker #(.DEPTH(3), .TW(2), .MD_LAT(5), .SELW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  typedef struct {
    string      name;
    logic [11:0] v;
  } exp_t;

  exp_t exp_q[$];
  bit   chk_pending = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] tv(input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] s3);
    return {s3, s2, s1};
  endfunction

  task automatic clr();
    hz.d_valid = 0; hz.d_rs_use = 0; hz.d_rs_addr = 0; hz.d_rs_tuse = 0;
    hz.d_rt_use = 0; hz.d_rt_addr = 0; hz.d_rt_tuse = 0;
    hz.d_wr_en = 0; hz.d_wr_addr = 0; hz.d_tnew = 0;
    hz.d_md_op = 0; hz.d_md_start = 0; hz.flush_e = 0;
  endtask

  task automatic instr(input logic rs_use, input logic [4:0] rs, input logic [1:0] rs_tuse,
                       input logic rt_use, input logic [4:0] rt, input logic [1:0] rt_tuse,
                       input logic wr_en, input logic [4:0] wr, input logic [1:0] tnew);
    clr();
    hz.d_valid = 1;
    hz.d_rs_use = rs_use; hz.d_rs_addr = rs; hz.d_rs_tuse = rs_tuse;
    hz.d_rt_use = rt_use; hz.d_rt_addr = rt; hz.d_rt_tuse = rt_tuse;
    hz.d_wr_en = wr_en; hz.d_wr_addr = wr; hz.d_tnew = tnew;
  endtask

  // Queue the expected outputs for the current cycle, then advance one clock.
  task automatic chk(input string name, input logic st, input logic [1:0] rs, input logic [1:0] rt,
                     input logic [5:0] tvec, input logic busy);
    exp_t e;
    e.name = name;
    e.v = {st, rs, rt, tvec, busy};
    exp_q.push_back(e);
    chk_pending = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_pending) begin
      exp_t e;
      logic [11:0] act;
      chk_pending = 1'b0;
      act = {hz.stall, hz.fwd_rs_sel, hz.fwd_rt_sel, hz.tnew_vec, hz.md_busy};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: output sampled with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL %s: got stall=%0b rs_sel=%0d rt_sel=%0d tnew_vec=%b md_busy=%0b, want stall=%0b rs_sel=%0d rt_sel=%0d tnew_vec=%b md_busy=%0b",
                   e.name, act[11], act[10:9], act[8:7], act[6:1], act[0],
                   e.v[11], e.v[10:9], e.v[8:7], e.v[6:1], e.v[0]);
        end
      end
    end
  end

  initial begin
    clr();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_state", 0, 0, 0, tv(0,0,0), 0);
    reset = 1'b0;

    // lw r2 then addu r8 <- r2, r7
    instr(0,0,0, 0,0,0, 1,5'd2,2'd2);
    chk("lw_r2", 0, 0, 0, tv(0,0,0), 0);
    instr(1,5'd2,1, 1,5'd7,1, 1,5'd8,2'd1);
    chk("addu_stall", 1, 1, 0, tv(2,0,0), 0);
    chk("addu_fwd", 0, 2, 0, tv(0,1,0), 0);

    // ori r3 then beq r3, r0
    instr(0,0,0, 0,0,0, 1,5'd3,2'd1);
    chk("ori_r3", 0, 0, 0, tv(1,0,0), 0);
    instr(1,5'd3,0, 1,5'd0,0, 0,0,0);
    chk("beq_stall", 1, 1, 0, tv(1,0,0), 0);
    chk("beq_fwd", 0, 2, 0, tv(0,0,0), 0);

    // two writers of r5, reader takes the youngest; r0 never matches
    instr(0,0,0, 0,0,0, 1,5'd5,2'd1);
    chk("w5_a", 0, 0, 0, tv(0,0,0), 0);
    chk("w5_b", 0, 0, 0, tv(1,0,0), 0);
    instr(1,5'd5,1, 1,5'd5,1, 0,0,0);
    chk("r5_youngest", 0, 1, 1, tv(1,0,0), 0);
    instr(0,0,0, 0,0,0, 1,5'd0,2'd1);
    chk("w_r0", 0, 0, 0, tv(0,0,0), 0);
    instr(1,5'd0,0, 1,5'd0,0, 0,0,0);
    chk("r0_read", 0, 0, 0, tv(1,0,0), 0);

    // mult then mflo r11: five stall cycles, release as md_busy drops
    instr(1,5'd9,1, 1,5'd10,1, 0,0,0);
    hz.d_md_op = 1; hz.d_md_start = 1;
    chk("mult", 0, 0, 0, tv(0,0,0), 0);
    instr(0,0,0, 0,0,0, 1,5'd11,2'd1);
    hz.d_md_op = 1;
    for (int i = 0; i < 5; i++) chk("mflo_stall", 1, 0, 0, tv(0,0,0), 1);
    chk("mflo_release", 0, 0, 0, tv(0,0,0), 0);
    clr();
    chk("after_mflo", 0, 0, 0, tv(1,0,0), 0);

    // flushed lw r4 leaves no trace
    instr(0,0,0, 0,0,0, 1,5'd4,2'd2);
    hz.flush_e = 1;
    chk("flush_lw", 0, 0, 0, tv(0,0,0), 0);
    instr(1,5'd4,0, 0,0,0, 0,0,0);
    chk("flush_read", 0, 0, 0, tv(0,0,0), 0);

    // rt path: equal Tnew/Tuse does not stall; last stage forwards
    instr(0,0,0, 0,0,0, 1,5'd6,2'd2);
    chk("lw_r6", 0, 0, 0, tv(0,0,0), 0);
    instr(1,5'd29,1, 1,5'd6,2, 0,0,0);
    chk("sw_equal", 0, 0, 1, tv(2,0,0), 0);
    instr(1,5'd0,0, 1,5'd6,0, 0,0,0);
    chk("beq_rt_stall", 1, 0, 2, tv(0,1,0), 0);
    chk("beq_rt_stage3", 0, 0, 3, tv(0,0,0), 0);

    // reset in the middle of an md stall
    instr(0,0,0, 0,0,0, 0,0,0);
    hz.d_md_op = 1; hz.d_md_start = 1;
    chk("mult2", 0, 0, 0, tv(0,0,0), 0);
    instr(0,0,0, 0,0,0, 1,5'd12,2'd1);
    hz.d_md_op = 1;
    chk("mflo2_stall", 1, 0, 0, tv(0,0,0), 1);
    reset = 1'b1;
    chk("reset_during_stall", 1, 0, 0, tv(0,0,0), 1);
    chk("reset_cleared", 0, 0, 0, tv(0,0,0), 0);
    reset = 1'b0;
    chk("after_reset_mflo", 0, 0, 0, tv(0,0,0), 0);

    clr();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
